// File: rtl/mc_core_v2.sv
// mc_core_v2: five-step multi-cycle Nios-II-subset core with per-access memory acknowledge.
// Steps: T1 fetch, T2 decode/register read, T3 execute, T4 memory, T5 writeback.
// Only T1 and T4 wait for iMemAck; all other steps advance every cycle.
// Optional feature macro: MC_CORE_V2_CALLRET_EN enables call (op 00) and ret (R-type OPX 05);
// when undefined both encodings are flagged illegal.
module mc_core_v2 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic        iClk,
    input  logic        nRst,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic        iMemAck,
    output logic [4:0]  oStep,
    output logic        oIllegal,
    output logic        oRetire
);
    localparam int unsigned RW = $clog2(NREGS);

    typedef enum logic [4:0] {
        T1 = 5'b00001,
        T2 = 5'b00010,
        T3 = 5'b00100,
        T4 = 5'b01000,
        T5 = 5'b10000
    } step_t;

    step_t          step;
    logic [31:0]    pc, ir, ra, rb, rm, rz, ry;
    logic [31:0]    regs [NREGS];

    logic [31:0]    simm, zimm, alu;
    logic [RW-1:0]  src1, src2, wr_idx;
    logic           is_ldw, is_stw, is_call, is_ret, ill, wr_en, br_taken;

    assign src1  = ir[27 +: RW];
    assign src2  = ir[22 +: RW];
    assign simm  = {{16{ir[21]}}, ir[21:6]};
    assign zimm  = {16'h0000, ir[21:6]};
    assign oStep     = step;
    assign oMemWData = rm;

    // Instruction decode, ALU and branch condition from IR and the latched operands
    always_comb begin
        alu      = 32'h0;
        is_ldw   = 1'b0;
        is_stw   = 1'b0;
        is_call  = 1'b0;
        is_ret   = 1'b0;
        ill      = 1'b0;
        wr_en    = 1'b0;
        br_taken = 1'b0;
        wr_idx   = ir[22 +: RW];
        case (ir[5:0])
            6'h04: begin alu = ra + simm; wr_en = 1'b1; end
            6'h0C: begin alu = ra & zimm; wr_en = 1'b1; end
            6'h14: begin alu = ra | zimm; wr_en = 1'b1; end
            6'h17: begin alu = ra + simm; wr_en = 1'b1; is_ldw = 1'b1; end
            6'h15: begin alu = ra + simm; is_stw = 1'b1; end
            6'h06: br_taken = 1'b1;
            6'h26: br_taken = (ra == rb);
            6'h1E: br_taken = (ra != rb);
            6'h16: br_taken = ($signed(ra) < $signed(rb));
            6'h3A: begin
                wr_idx = ir[17 +: RW];
                wr_en  = 1'b1;
                case (ir[16:11])
                    6'h31: alu = ra + rb;
                    6'h39: alu = ra - rb;
                    6'h0E: alu = ra & rb;
                    6'h16: alu = ra | rb;
                    6'h10: alu = {31'h0, ($signed(ra) < $signed(rb))};
`ifdef MC_CORE_V2_CALLRET_EN
                    6'h05: begin is_ret = 1'b1; wr_en = 1'b0; end
`endif
                    default: begin ill = 1'b1; wr_en = 1'b0; end
                endcase
            end
`ifdef MC_CORE_V2_CALLRET_EN
            6'h00: is_call = 1'b1;
`endif
            default: ill = 1'b1;
        endcase
    end

    // Step sequencer, datapath registers, register file and registered bus outputs
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            step      <= T1;
            pc        <= RESET_PC;
            ir        <= 32'h0;
            ra        <= 32'h0;
            rb        <= 32'h0;
            rm        <= 32'h0;
            rz        <= 32'h0;
            ry        <= 32'h0;
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= 32'h0;
            oMemAddr  <= RESET_PC;
            oMemRead  <= 1'b1;
            oMemWrite <= 1'b0;
            oIllegal  <= 1'b0;
            oRetire   <= 1'b0;
        end else begin
            oIllegal <= 1'b0;
            oRetire  <= 1'b0;
            case (step)
                T1: begin
                    if (iMemAck) begin
                        ir       <= iMemRData;
                        pc       <= pc + 32'd4;
                        oMemRead <= 1'b0;
                        step     <= T2;
                    end
                end
                T2: begin
                    ra       <= regs[src1];
                    rb       <= regs[src2];
                    oIllegal <= ill;
                    step     <= T3;
                end
                T3: begin
                    rz <= alu;
                    rm <= rb;
                    if (br_taken) begin
                        pc <= pc + simm;
                    end else if (is_call) begin
                        regs[RW'(31)] <= pc;
                        pc <= {pc[31:28], ir[31:6], 2'b00};
                    end else if (is_ret) begin
                        pc <= regs[RW'(31)];
                    end
                    oMemAddr  <= alu;
                    oMemRead  <= is_ldw;
                    oMemWrite <= is_stw;
                    step      <= T4;
                end
                T4: begin
                    if (!(oMemRead || oMemWrite)) begin
                        ry      <= rz;
                        oRetire <= 1'b1;
                        step    <= T5;
                    end else if (iMemAck) begin
                        ry        <= oMemRead ? iMemRData : rz;
                        oMemRead  <= 1'b0;
                        oMemWrite <= 1'b0;
                        oRetire   <= 1'b1;
                        step      <= T5;
                    end
                end
                T5: begin
                    if (wr_en && (wr_idx != '0)) regs[wr_idx] <= ry;
                    oMemAddr <= pc;
                    oMemRead <= 1'b1;
                    step     <= T1;
                end
                default: step <= T1;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_core_v2.sv
// tb_mc_core_v2: instruction-level bench for mc_core_v2 (RESET_PC=32'h100, NREGS=32).
// A small architectural model predicts the bus events of each instruction into a queue;
// the bench then plays memory for the core and pops/compares as the events appear.
module tb_mc_core_v2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        iClk, nRst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ack;
    logic [4:0]  step;
    logic        illegal, retire;

    mc_core_v2 #(.RESET_PC(RST_PC), .NREGS(32)) dut (
        .iClk(iClk), .nRst(nRst),
        .oMemAddr(mem_addr), .oMemWData(mem_wdata), .iMemRData(mem_rdata),
        .oMemRead(mem_read), .oMemWrite(mem_write), .iMemAck(mem_ack),
        .oStep(step), .oIllegal(illegal), .oRetire(retire)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        int          kind;   // 1 fetch, 2 illegal, 3 load, 4 store, 5 retire
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] mr [32];
    logic [31:0] mpc;
    logic [31:0] dmem [logic [31:0]];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input int a, input int b, input int imm);
        return {5'(a), 5'(b), 16'(imm), op};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] x, input int a, input int b, input int c);
        return {5'(a), 5'(b), 5'(c), x, 5'd0, 6'h3A};
    endfunction

    task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        evq.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (evq.size() == 0) begin
            check("ev_unexpected", 32'(kind), 32'h0);
            return;
        end
        e = evq.pop_front();
        check("ev_kind", 32'(kind), 32'(e.kind));
        if (e.kind != kind) return;
        case (kind)
            1: check("fetch_addr", addr, e.addr);
            3: check("load_addr", addr, e.addr);
            4: begin check("store_addr", addr, e.addr); check("store_data", data, e.data); end
            5: check("retire_cycles", data, e.data);
            default: ;
        endcase
    endtask

    // Architectural model of one instruction: predicts its event sequence and updates state
    task automatic model_exec(input logic [31:0] ir, input int fw, input int mw);
        logic [4:0]  a, b, c;
        logic [5:0]  op, x;
        logic [31:0] va, vb, simm, zimm, res, npc, ea;
        bit          ill, wr;
        int          kind;
        logic [4:0]  wd;
        a = ir[31:27]; b = ir[26:22]; c = ir[21:17];
        op = ir[5:0]; x = ir[16:11];
        va = mr[a]; vb = mr[b];
        simm = {{16{ir[21]}}, ir[21:6]};
        zimm = {16'h0, ir[21:6]};
        res = 32'h0; ea = 32'h0; ill = 0; wr = 0; kind = 0; wd = b;
        push_ev(1, mpc, 32'h0);
        npc = mpc + 32'd4;
        case (op)
            6'h04: begin res = va + simm; wr = 1; end
            6'h0C: begin res = va & zimm; wr = 1; end
            6'h14: begin res = va | zimm; wr = 1; end
            6'h17: begin ea = va + simm; kind = 3; wr = 1; res = dmem.exists(ea) ? dmem[ea] : 32'h0; end
            6'h15: begin ea = va + simm; kind = 4; end
            6'h06: npc = npc + simm;
            6'h26: if (va == vb) npc = npc + simm;
            6'h1E: if (va != vb) npc = npc + simm;
            6'h16: if ($signed(va) < $signed(vb)) npc = npc + simm;
            6'h3A: begin
                wd = c; wr = 1;
                case (x)
                    6'h31: res = va + vb;
                    6'h39: res = va - vb;
                    6'h0E: res = va & vb;
                    6'h16: res = va | vb;
                    6'h10: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                    default: begin ill = 1; wr = 0; end
                endcase
            end
            default: ill = 1;
        endcase
        if (ill) push_ev(2, 32'h0, 32'h0);
        if (kind == 3) push_ev(3, ea, 32'h0);
        if (kind == 4) begin push_ev(4, ea, vb); dmem[ea] = vb; end
        push_ev(5, 32'h0, 32'(5 + fw + ((kind != 0) ? mw : 0)));
        if (wr && wd != 5'd0) mr[wd] = res;
        mpc = npc;
    endtask

    // Drive one instruction through the core, acting as memory; abort>0 resets mid-store
    task automatic run_instr(input logic [31:0] ir, input int fw, input int mw,
                             input bit stray, input int abort);
        int cyc, wcnt;
        bit done, inreq;
        cyc = 0; wcnt = 0; done = 0; inreq = 0;
        model_exec(ir, fw, mw);
        while (!done && cyc < 60) begin
            @(negedge iClk);
            cyc++;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0BAD_F00D;
            if (mem_read && step == 5'b00001) begin
                if (!inreq) begin pop_cmp(1, mem_addr, 32'h0); inreq = 1; wcnt = 0; end
                if (wcnt == fw) begin mem_ack = 1'b1; mem_rdata = ir; inreq = 0; end
                else wcnt++;
            end else if (step == 5'b01000 && (mem_read || mem_write)) begin
                if (!inreq) begin
                    pop_cmp(mem_write ? 4 : 3, mem_addr, mem_wdata);
                    inreq = 1; wcnt = 0;
                end
                if (abort > 0 && wcnt == abort) begin
                    nRst = 1'b0;
                    #1;
                    check("rst_async_write", 32'(mem_write), 32'h0);
                    check("rst_async_read", 32'(mem_read), 32'h1);
                    check("rst_async_step", 32'(step), 32'h1);
                    check("rst_async_addr", mem_addr, RST_PC);
                    evq.delete();
                    mpc = RST_PC;
                    for (int i = 0; i < 32; i++) mr[i] = 32'h0;
                    @(negedge iClk);
                    nRst = 1'b1;
                    return;
                end
                if (wcnt == mw) begin
                    mem_ack = 1'b1;
                    mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : 32'h0;
                    inreq = 0;
                end else wcnt++;
            end else if (stray) begin
                mem_ack = 1'b1;
            end
            if (illegal) pop_cmp(2, 32'h0, 32'h0);
            if (retire) begin pop_cmp(5, 32'h0, 32'(cyc)); done = 1; end
        end
        if (!done) check("retire_timeout", 32'h0, 32'h1);
        check("events_left", 32'(evq.size()), 32'h0);
        evq.delete();
    endtask

    initial begin
        nRst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        mpc = RST_PC;
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;
        #2 nRst = 1'b0;
        repeat (2) @(negedge iClk);
        nRst = 1'b1;
        // Reset state, and no advance without an acknowledge
        for (int k = 0; k < 3; k++) begin
            @(negedge iClk);
            check("reset_step", 32'(step), 32'h1);
            check("reset_read", 32'(mem_read), 32'h1);
            check("reset_addr", mem_addr, RST_PC);
            check("reset_write", 32'(mem_write), 32'h0);
            check("reset_illegal", 32'(illegal), 32'h0);
            check("reset_retire", 32'(retire), 32'h0);
        end
        // Arithmetic
        run_instr(itype(6'h04, 0, 2, 5), 0, 0, 0, 0);
        run_instr(itype(6'h04, 0, 3, -3), 2, 0, 0, 0);
        run_instr(rtype(6'h31, 2, 3, 4), 0, 0, 1, 0);
        run_instr(rtype(6'h39, 3, 2, 5), 0, 0, 1, 0);
        run_instr(itype(6'h15, 0, 4, 12), 0, 0, 0, 0);
        run_instr(itype(6'h15, 0, 5, 16), 0, 1, 1, 0);
        // Store/load with delayed acknowledge
        run_instr(itype(6'h15, 0, 2, 8), 0, 3, 0, 0);
        run_instr(itype(6'h17, 0, 6, 8), 0, 3, 1, 0);
        run_instr(itype(6'h15, 0, 6, 20), 0, 0, 0, 0);
        // Logic and compare
        run_instr(itype(6'h0C, 3, 7, 16'hFFF0), 0, 0, 0, 0);
        run_instr(itype(6'h14, 0, 8, 16'h8000), 1, 0, 0, 0);
        run_instr(rtype(6'h0E, 3, 7, 9), 0, 0, 0, 0);
        run_instr(rtype(6'h16, 2, 8, 10), 0, 0, 0, 0);
        run_instr(rtype(6'h10, 3, 2, 11), 0, 0, 0, 0);
        run_instr(rtype(6'h10, 2, 3, 12), 0, 0, 0, 0);
        for (int r = 7; r <= 12; r++) run_instr(itype(6'h15, 0, r, 24 + 4 * (r - 7)), 0, 0, 0, 0);
        // Branches
        run_instr(itype(6'h16, 3, 2, 8), 0, 0, 0, 0);
        run_instr(itype(6'h26, 2, 3, 8), 0, 0, 1, 0);
        run_instr(itype(6'h1E, 2, 3, 4), 0, 0, 0, 0);
        run_instr(itype(6'h16, 2, 3, 8), 0, 0, 0, 0);
        run_instr(itype(6'h06, 0, 0, 16), 1, 0, 0, 0);
        // Illegal encodings and r0 write suppression
        run_instr(itype(6'h3F, 0, 13, 16'h0055), 0, 0, 0, 0);
        run_instr(rtype(6'h05, 2, 3, 14), 0, 0, 1, 0);
        run_instr(rtype(6'h00, 2, 3, 14), 0, 0, 0, 0);
        run_instr(itype(6'h04, 0, 0, 7), 0, 0, 0, 0);
        run_instr(itype(6'h15, 0, 0, 48), 0, 0, 0, 0);
        run_instr(itype(6'h15, 0, 13, 52), 0, 0, 0, 0);
        run_instr(itype(6'h15, 0, 14, 56), 0, 0, 0, 0);
        // Wrap-around
        run_instr(itype(6'h04, 0, 15, -1), 0, 0, 0, 0);
        run_instr(rtype(6'h31, 15, 2, 16), 0, 0, 0, 0);
        run_instr(itype(6'h15, 0, 16, 60), 0, 2, 0, 0);
        // Reset in the middle of a held store, then state is back to reset values
        run_instr(itype(6'h15, 0, 2, 64), 0, 10, 0, 2);
        run_instr(itype(6'h15, 0, 2, 0), 0, 0, 0, 0);
        run_instr(itype(6'h04, 0, 2, 9), 0, 0, 0, 0);
        run_instr(itype(6'h15, 0, 2, 4), 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
